// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared types, defaults and slice-width helper for pipe_addsub
//
// Purpose: common definitions for the pipelined adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and slice count
//   op_e                           : operation selected by in_sub
//   slice_w()                      : bits added per slice (width / stages)
//   slice_pl_t                     : slice payload at the default width
//                                    (partial sum, pending operands, carry)
package pipe_addsub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Each slice carries the whole operand pair forward. The bits below the
  // slice's window are already summed; the bits above it are still pending.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] sum;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
    logic                     carry;
  } slice_pl_t;

endpackage

// File: rtl/pipe_addsub_if.sv
// rtl/pipe_addsub_if.sv - operand/result handshake bundle for pipe_addsub
//
// Purpose: groups both valid/ready channels of the adder.
//   in_valid/in_ready           : operand beat handshake
//   in_a/in_b/in_ci/in_sub      : operands, carry-in, subtract select
//   out_valid/out_ready         : result beat handshake
//   out_sum/out_co/out_ovf      : result, carry out, signed overflow
// Modports: master = source/sink side, slave = the adder.
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf
  );

endinterface

// File: rtl/pipe_addsub_slice.sv
// rtl/pipe_addsub_slice.sv - one registered slice of the pipelined carry chain
//
// Purpose: adds operand window [K*SLICE_W +: SLICE_W] plus the incoming carry
// and registers the updated payload.
//   clk, rst  : clock, asynchronous active-high reset
//   advance   : slice may load this cycle (it is empty or its successor moves)
//   in_valid  : upstream holds a beat
//   in_pl     : upstream payload
//   valid     : this slice holds a beat
//   pl        : registered payload
module pipe_addsub_slice
  import pipe_addsub_pkg::*;
#(
  parameter int  SLICE_W   = 4,
  parameter int  K         = 0,
  parameter type payload_t = slice_pl_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     advance,
  input  logic     in_valid,
  input  payload_t in_pl,
  output logic     valid,
  output payload_t pl
);

  localparam int LO = K * SLICE_W;

  payload_t           next_pl;
  logic [SLICE_W:0]   part;

  // SLICE_W+1 bit add: the extra top bit is the carry into the next slice.
  always_comb begin
    next_pl = in_pl;
    part    = {1'b0, in_pl.a[LO +: SLICE_W]}
            + {1'b0, in_pl.b[LO +: SLICE_W]}
            + {{SLICE_W{1'b0}}, in_pl.carry};
    next_pl.sum[LO +: SLICE_W] = part[SLICE_W-1:0];
    next_pl.carry              = part[SLICE_W];
  end

  // Holding (valid && !advance) freezes the payload. A bubble arriving
  // clears valid but leaves the old payload, which nobody consumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pl    <= '0;
    end else if (advance) begin
      valid <= in_valid;
      if (in_valid) begin
        pl <= next_pl;
      end
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit add/subtract with valid/ready backpressure
//
// Purpose: A+B+ci or A-B, carry chain split across STAGES registered slices.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset, discards every in-flight beat
//   bus  : pipe_addsub_if slave (operand channel in, result channel out)
// Latency is STAGES cycles; one beat per cycle; bubbles collapse under stall.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  pipe_addsub_if.slave  bus
);

  localparam int SW = slice_w(WIDTH, STAGES);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
  } payload_t;

  op_e             op;
  payload_t        head;
  payload_t        outs [STAGES];
  payload_t        last;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   adv;

  assign op = op_e'(bus.in_sub);

  // Subtract is A + ~B + 1; the user carry-in is dropped for subtract.
  always_comb begin
    head       = '0;
    head.a     = bus.in_a;
    head.b     = (op == OP_SUB) ? ~bus.in_b : bus.in_b;
    head.carry = (op == OP_SUB) ? 1'b1 : bus.in_ci;
  end

  // Ready ripples back from the consumer: a slice can take a beat if it is
  // empty or the slice after it is moving on this cycle.
  always_comb begin
    adv         = '0;
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      pipe_addsub_slice #(
        .SLICE_W   (SW),
        .K         (k),
        .payload_t (payload_t)
      ) u_slice (
        .clk      (clk),
        .rst      (rst),
        .advance  (adv[k]),
        .in_valid (bus.in_valid),
        .in_pl    (head),
        .valid    (vld[k]),
        .pl       (outs[k])
      );
    end else begin : g_rest
      pipe_addsub_slice #(
        .SLICE_W   (SW),
        .K         (k),
        .payload_t (payload_t)
      ) u_slice (
        .clk      (clk),
        .rst      (rst),
        .advance  (adv[k]),
        .in_valid (vld[k-1]),
        .in_pl    (outs[k-1]),
        .valid    (vld[k]),
        .pl       (outs[k])
      );
    end
  end

  assign last = outs[STAGES-1];

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_sum   = last.sum;
  assign bus.out_co    = last.carry;
  // Carry into the MSB is recovered from the MSB sum bit and its two
  // (already conditioned) operand bits, so no extra register is needed.
  assign bus.out_ovf   = last.carry
                       ^ (last.sum[WIDTH-1] ^ last.a[WIDTH-1] ^ last.b[WIDTH-1]);

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - self-checking bench for pipe_addsub (STAGES 4, 1 and 16)
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ci;
  logic        in_sub;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];

  logic        s_in_ready;
  logic        s_out_valid;
  logic [17:0] s_out;

  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(16)) b4 ();
  pipe_addsub_if #(.WIDTH(16)) b1 ();
  pipe_addsub_if #(.WIDTH(16)) b16 ();

  assign b4.in_valid  = in_valid;  assign b1.in_valid  = in_valid;  assign b16.in_valid  = in_valid;
  assign b4.in_a      = in_a;      assign b1.in_a      = in_a;      assign b16.in_a      = in_a;
  assign b4.in_b      = in_b;      assign b1.in_b      = in_b;      assign b16.in_b      = in_b;
  assign b4.in_ci     = in_ci;     assign b1.in_ci     = in_ci;     assign b16.in_ci     = in_ci;
  assign b4.in_sub    = in_sub;    assign b1.in_sub    = in_sub;    assign b16.in_sub    = in_sub;
  assign b4.out_ready = out_ready; assign b1.out_ready = out_ready; assign b16.out_ready = out_ready;

  pipe_addsub #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  pipe_addsub #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
  pipe_addsub #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  // Reference: integer arithmetic on the operands, {sum, co, ovf}.
  function automatic logic [17:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic ci, input logic sub);
    int          sa;
    int          sb;
    int          r;
    logic [15:0] s;
    logic        co;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = sa - sb;
      s  = a - b;
      co = (a >= b);
    end else begin
      r  = sa + sb + int'(ci);
      s  = a + b + {15'd0, ci};
      co = (int'(a) + int'(b) + int'(ci)) > 65535;
    end
    return {s, co, (r > 32767) || (r < -32768)};
  endfunction

  // One clock: drive at negedge, sample 1ns later, log transfers on the 4-stage DUT.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sub, input logic ordy);
    in_valid = v; in_a = a; in_b = b; in_ci = ci; in_sub = sub; out_ready = ordy;
    #1;
    s_in_ready  = b4.in_ready;
    s_out_valid = b4.out_valid;
    s_out       = {b4.out_sum, b4.out_co, b4.out_ovf};
    if (!rst && v && s_in_ready) exp_q.push_back(ref_result(a, b, ci, sub));
    if (!rst && s_out_valid && ordy) got_q.push_back(s_out);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", b4.out_valid); end
    checks++; if (b4.out_sum !== 16'h0000) begin errors++; $display("FAIL reset_out_sum got=%h want=0000", b4.out_sum); end
    checks++; if (b4.out_co !== 1'b0) begin errors++; $display("FAIL reset_out_co got=%b want=0", b4.out_co); end
    checks++; if (b4.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%b want=0", b4.out_ovf); end
    checks++; if (b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid_s1_s16 got=%b%b want=00", b1.out_valid, b16.out_valid); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", b4.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        tc [6];
    logic        ts [6];
    logic [17:0] te [6];
    int lat;
    ta = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
    tb = '{16'h0FF1, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
    tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    te = '{{16'h2226, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
           {16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}, {16'h000D, 2'b10}};
    exp_q.delete(); got_q.delete();
    lat = -1;
    for (int i = 0; i < 30 && got_q.size() < 6; i++) begin
      if (i < 6) step(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
      else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (s_out_valid && lat < 0) lat = i;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d want=4", lat); end
    checks++; if (got_q.size() !== 6 || exp_q.size() !== 6) begin
      errors++; $display("FAIL directed_count got=%0d accepted=%0d want=6", got_q.size(), exp_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== te[i]) begin
        errors++; $display("FAIL directed_%0d got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                           i, got_q[i][17:2], got_q[i][1], got_q[i][0], te[i][17:2], te[i][1], te[i][0]);
      end
    end
  endtask

  task automatic test_backpressure;
    int drop_at;
    exp_q.delete(); got_q.delete();
    drop_at = -1;
    for (int c = 0; c < 60 && got_q.size() < 8; c++) begin
      step(exp_q.size() < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           !(c >= 3 && c <= 9));
      if (drop_at < 0 && !s_in_ready) drop_at = exp_q.size();
      if (c >= 4 && c <= 9) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out !== exp_q[0]) begin
          errors++; $display("FAIL stall_hold_c%0d got valid=%b out=%h want valid=1 out=%h", c, s_out_valid, s_out, exp_q[0]);
        end
      end
    end
    checks++; if (drop_at !== 4) begin errors++; $display("FAIL in_ready_drop got=%0d want=4", drop_at); end
    checks++; if (got_q.size() !== 8) begin errors++; $display("FAIL bp_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order_%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubble;
    logic v;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c <= 10; c++) begin
      v = (c == 0) || (c == 3) || (c >= 8);
      step(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      checks++;
      if (s_in_ready !== (c < 10)) begin errors++; $display("FAIL bubble_in_ready_c%0d got=%b want=%b", c, s_in_ready, c < 10); end
      if (c >= 4) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out !== exp_q[0]) begin
          errors++; $display("FAIL bubble_hold_c%0d got valid=%b out=%h want valid=1 out=%h", c, s_out_valid, s_out, exp_q[0]);
        end
      end
    end
    checks++; if (exp_q.size() !== 4) begin errors++; $display("FAIL bubble_accepted got=%0d want=4", exp_q.size()); end
    for (int c = 0; c < 20 && got_q.size() < exp_q.size(); c++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bubble_drain got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bubble_order_%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    logic        prev_stall;
    logic [17:0] prev_out;
    logic [15:0] a;
    logic [15:0] b;
    int          bad;
    exp_q.delete(); got_q.delete();
    prev_stall = 1'b0; prev_out = '0; bad = 0;
    for (int c = 0; c < 400; c++) begin
      logic ordy;
      a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      ordy = (c >= 340) || ($urandom_range(0, 3) != 0);
      step((c < 340) && ($urandom_range(0, 3) != 0), a, b, 1'($urandom), 1'($urandom), ordy);
      if (prev_stall) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out !== prev_out) begin
          errors++; $display("FAIL rand_stable_c%0d got valid=%b out=%h want valid=1 out=%h", c, s_out_valid, s_out, prev_out);
        end
      end
      prev_stall = s_out_valid && !ordy;
      prev_out   = s_out;
    end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 5) $display("FAIL rand_beat_%0d got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_results got=%0d bad beats want=0", bad); end
  endtask

  task automatic test_reset_midflight;
    logic seen;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 5; c++) step(c < 3, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid_s4 got=%b want=1", s_out_valid); end
    checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid_s1 got=%b want=1", b1.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_s4 got=%b want=0", b4.out_valid); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_s1 got=%b want=0", b1.out_valid); end
    checks++; if (b16.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_s16 got=%b want=0", b16.out_valid); end
    checks++; if (b4.out_sum !== 16'h0000) begin errors++; $display("FAIL async_reset_sum got=%h want=0000", b4.out_sum); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (s_out_valid || b1.out_valid || b16.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stale_after_reset got=%b want=0", seen); end
    step(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10 && got_q.size() < 1; c++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== {16'h1000, 2'b00}) begin
      errors++; $display("FAIL post_reset_beat got n=%0d val=%h want n=1 val=%h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 18'h0, {16'h1000, 2'b00});
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_bubble();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
